dmem_arbiter: RTL

- Shares the single-ported data memory between two requesters: port 0 is the core load/store unit and port 1 is the DMA/debug loader.
- Each cycle the block selects at most one request and drives the memory's load/store enables, alucode, address and write data.
- It routes the registered read data back to the owning requester, rejects misaligned accesses, and supports a bounded DMA lock for bursts.

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_arb_rr.sv | 10 +
 rtl/dmem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, port indices and load/store decode for the data memory arbiter
package dmem_arb_pkg;
  typedef enum logic {ARB, LOCK} state_t;
  localparam int P_CORE = 0;
  localparam int P_DMA = 1;
  localparam logic [5:0] ALU_LB  = 6'd11;
  localparam logic [5:0] ALU_LH  = 6'd12;
  localparam logic [5:0] ALU_LW  = 6'd13;
  localparam logic [5:0] ALU_LBU = 6'd14;
  localparam logic [5:0] ALU_LHU = 6'd15;
  localparam logic [5:0] ALU_SB  = 6'd16;
  localparam logic [5:0] ALU_SH  = 6'd17;
  localparam logic [5:0] ALU_SW  = 6'd18;
  function automatic logic is_load_op(input logic [5:0] c);
    return c inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
  endfunction
  function automatic logic is_store_op(input logic [5:0] c);
    return c inside {ALU_SB, ALU_SH, ALU_SW};
  endfunction
  function automatic logic misaligned(input logic [5:0] c, input logic [1:0] a);
    return ((c inside {ALU_LH, ALU_LHU, ALU_SH}) && a == 2'b11) ||
           ((c inside {ALU_LW, ALU_SW}) && a != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr: two-way round-robin pick; prio names the winner on conflict and flips only then
module dmem_arb_rr (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       prio_nxt
);
  assign gnt = (&req) ? (prio ? 2'b10 : 2'b01) : req;
  assign prio_nxt = (&req) ? ~prio : prio;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/DMA data memory arbiter with bounded DMA lock; DMEM_ARB_PERF_EN adds conflict/forced counters
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 16,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_i,
  input  logic [1:0][5:0] alucode_i,
  input  logic [1:0][31:0] addr_i,
  input  logic [1:0][31:0] wdata_i,
  input  logic            lock_i,
  output logic [1:0]      gnt_o,
  output logic [1:0]      rvalid_o,
  output logic [31:0]     rdata_o,
  output logic            err_o,
  output logic            mem_is_load,
  output logic            mem_is_store,
  output logic [5:0]      mem_alucode,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]     conflict_cnt,
  output logic [31:0]     forced_cnt
`endif
);
  state_t state, state_nxt;
  logic prio, prio_nxt, rr_prio, force_rel, any, sel, mis, err_q, ld_q;
  logic [1:0] valid, rr_gnt, rv_q;
  logic [CNT_W-1:0] lock_cnt, cnt_nxt;
  logic [5:0] sel_code;
  logic [31:0] sel_addr;
  assign valid[0] = req_i[0] && (is_load_op(alucode_i[0]) || is_store_op(alucode_i[0]));
  assign valid[1] = req_i[1] && (is_load_op(alucode_i[1]) || is_store_op(alucode_i[1]));
  dmem_arb_rr u_rr (.req(valid), .prio(prio), .gnt(rr_gnt), .prio_nxt(rr_prio));
  assign force_rel = state == LOCK && lock_cnt == CNT_W'(MAX_LOCK) && valid[P_CORE];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      prio <= 1'b0;
      lock_cnt <= '0;
      rv_q <= '0;
      err_q <= 1'b0;
      ld_q <= 1'b0;
    end else begin
      state <= state_nxt;
      prio <= prio_nxt;
      lock_cnt <= cnt_nxt;
      rv_q <= gnt_o;
      err_q <= any && mis;
      ld_q <= mem_is_load;
    end
  end
  always_comb begin
    state_nxt = state;
    prio_nxt = prio;
    cnt_nxt = lock_cnt;
    if (state == ARB) begin
      prio_nxt = rr_prio;
      if (rr_gnt[P_DMA] && lock_i) begin
        state_nxt = LOCK;
        cnt_nxt = CNT_W'(1);
      end
    end else if (force_rel) begin
      state_nxt = ARB;
      prio_nxt = 1'b1;
      cnt_nxt = '0;
    end else if (!lock_i) begin
      state_nxt = ARB;
      prio_nxt = 1'b0;
      cnt_nxt = '0;
    end else if (valid[P_DMA] && lock_cnt != CNT_W'(MAX_LOCK)) begin
      cnt_nxt = lock_cnt + CNT_W'(1);
    end
  end
  always_comb begin
    gnt_o = state == ARB ? rr_gnt : force_rel ? 2'b01 : {valid[P_DMA], 1'b0};
    any = |gnt_o;
    sel = gnt_o[P_DMA];
    sel_code = alucode_i[sel];
    sel_addr = addr_i[sel];
    mis = misaligned(sel_code, sel_addr[1:0]);
    mem_is_load = any && !mis && is_load_op(sel_code);
    mem_is_store = any && !mis && is_store_op(sel_code);
    mem_alucode = any ? sel_code : '0;
    mem_addr = any ? sel_addr : '0;
    mem_wdata = any ? wdata_i[sel] : '0;
    rvalid_o = rv_q;
    err_o = err_q;
    rdata_o = ld_q ? mem_rdata : '0;
  end
`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      forced_cnt <= '0;
    end else begin
      conflict_cnt <= conflict_cnt + 32'(&req_i);
      forced_cnt <= forced_cnt + 32'(force_rel);
    end
  end
`endif
endmodule
